// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter that turns an async FIFO's empty/rinc/rdata port
// into a valid/ready stream. Define FIFO_RD_STREAM_CNT_EN to add the beat_cnt output.
module fifo_rd_stream #(
  parameter int W      = 4,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         fifo_empty,
  input  logic [W-1:0] fifo_rdata,
  output logic         fifo_rinc,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]  beat_cnt
`endif
);

  localparam logic LAT1 = (RD_LAT != 32'sd0);

  logic [1:0]   occ_r;
  logic [1:0]   occ_next_s;
  logic         inflight_r;
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [W-1:0] buf_r [2];
  logic         pop_s;
  logic         issue_raw_s;
  logic         capture_s;
  logic [2:0]   level_s;
  logic [2:0]   limit_s;

  assign m_valid   = (occ_r != 2'd0);
  assign m_data    = buf_r[rd_ptr_r];
  // Reset gating lives only on the port so no flop sees resetn as data.
  assign fifo_rinc = issue_raw_s & resetn;

  // Issue/capture decision: a read may start only if its beat is guaranteed a slot.
  always_comb begin
    pop_s       = m_valid & m_ready;
    level_s     = {1'b0, occ_r} + {2'b00, inflight_r};
    limit_s     = 3'd2 + {2'b00, pop_s};
    issue_raw_s = ~fifo_empty & (level_s < limit_s);
    if (LAT1) begin
      capture_s = inflight_r;
    end else begin
      capture_s = issue_raw_s;
    end
  end

  // Occupancy update from this cycle's capture and pop.
  always_comb begin
    occ_next_s = occ_r;
    case ({capture_s, pop_s})
      2'b10:   occ_next_s = occ_r + 2'd1;
      2'b01:   occ_next_s = occ_r - 2'd1;
      default: occ_next_s = occ_r;
    endcase
  end

  // Control registers: occupancy, in-flight read flag and buffer pointers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
    end else begin
      occ_r      <= occ_next_s;
      inflight_r <= LAT1 ? issue_raw_s : 1'b0;
      if (capture_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Two-entry data buffer; cleared on reset so a dropped beat can never resurface.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_r[0] <= {W{1'b0}};
      buf_r[1] <= {W{1'b0}};
    end else if (capture_s) begin
      buf_r[wr_ptr_r] <= fifo_rdata;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  // Delivered-beat counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= 16'h0000;
    end else if (pop_s) begin
      beat_cnt <= beat_cnt + 16'h0001;
    end
  end
`endif

  // Buffered plus in-flight beats must never exceed the two buffer slots.
  a_level: assert property (@(posedge clk) disable iff (!resetn)
    ({1'b0, occ_r} + {2'b00, inflight_r}) <= 3'd2);
  a_rinc_empty: assert property (@(posedge clk) disable iff (!resetn)
    fifo_rinc |-> !fifo_empty);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: RD_LAT=1 instance against a FIFO model plus an
// RD_LAT=0 instance for the zero-latency read path.
`timescale 1ns/1ps
module tb_fifo_rd_stream;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  int           n_cmp = 0;
  int           n_fail = 0;

  // RD_LAT=1 instance and its FIFO model
  logic         fifo_empty, fifo_rinc, m_valid, m_ready, hold_empty;
  logic [W-1:0] fifo_rdata, m_data;
  logic [W-1:0] mem [0:2047];
  int           wptr = 0;
  int           rptr = 0;
  assign fifo_empty = (rptr == wptr) || hold_empty;
  always @(posedge clk) begin
    if (fifo_rinc && !fifo_empty) begin
      fifo_rdata <= mem[rptr[10:0]];
      rptr       <= rptr + 1;
    end
  end

  // RD_LAT=0 instance and its FIFO model
  logic         fifo_empty0, fifo_rinc0, m_valid0, m_ready0;
  logic [W-1:0] fifo_rdata0, m_data0;
  logic [W-1:0] mem0 [0:15];
  int           wptr0 = 0;
  int           rptr0 = 0;
  assign fifo_empty0 = (rptr0 == wptr0);
  assign fifo_rdata0 = mem0[rptr0[3:0]];
  always @(posedge clk) begin
    if (fifo_rinc0 && !fifo_empty0) rptr0 <= rptr0 + 1;
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] beat_cnt, beat_cnt0;
`endif

  fifo_rd_stream #(.W(W), .RD_LAT(1)) dut (
    .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rinc(fifo_rinc), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );

  fifo_rd_stream #(.W(W), .RD_LAT(0)) dut0 (
    .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty0), .fifo_rdata(fifo_rdata0),
    .fifo_rinc(fifo_rinc0), .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0)
`ifdef FIFO_RD_STREAM_CNT_EN
    , .beat_cnt(beat_cnt0)
`endif
  );

  logic         obs_valid, obs_rinc, obs_empty, obs_pop, obs_acc;
  logic [W-1:0] obs_data;
  int           acc_cnt = 0;
  int           pop_cnt = 0;
  int           exp_idx = 0;

  // Sample the RD_LAT=1 instance mid-cycle, then move to the next falling edge.
  task automatic tick();
    #1;
    obs_valid = m_valid;
    obs_data  = m_data;
    obs_rinc  = fifo_rinc;
    obs_empty = fifo_empty;
    obs_pop   = m_valid & m_ready;
    obs_acc   = fifo_rinc & ~fifo_empty;
    if (obs_pop) pop_cnt++;
    if (obs_acc) acc_cnt++;
    @(negedge clk);
  endtask

  task automatic load(input int n, input logic [3:0] first);
    for (int k = 0; k < n; k++) begin
      mem[wptr[10:0]] = first + k[3:0];
      wptr++;
    end
  endtask

  task automatic test_reset();
    int lat;
    int guard;
    load(8, 4'h1);
    m_ready = 1'b1;
    resetn  = 1'b0;
    repeat (2) tick();
    n_cmp += 3;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", obs_valid); end
    if (obs_data !== 4'h0)  begin n_fail++; $display("FAIL rst_data: got %h want 0", obs_data); end
    if (obs_rinc !== 1'b0)  begin n_fail++; $display("FAIL rst_rinc: got %b want 0", obs_rinc); end
    resetn = 1'b1;
    tick();
    n_cmp++;
    if (obs_rinc !== 1'b1) begin n_fail++; $display("FAIL rst_first_rinc: got %b want 1", obs_rinc); end
    lat = 0;
    while (!obs_valid && lat < 10) begin tick(); lat++; end
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("FAIL rst_latency: got %0d want 2", lat); end
    guard = 0;
    while (guard < 30) begin
      if (obs_pop) begin
        n_cmp++;
        if (obs_data !== mem[exp_idx[10:0]]) begin
          n_fail++; $display("FAIL rst_drain_data: got %h want %h", obs_data, mem[exp_idx[10:0]]);
        end
        exp_idx++;
      end
      if (exp_idx == wptr) break;
      tick();
      guard++;
    end
    n_cmp++;
    if (exp_idx != 8) begin n_fail++; $display("FAIL rst_drain_count: got %0d want 8", exp_idx); end
    tick();
  endtask

  task automatic test_stream();
    int lat;
    logic [3:0] want;
    load(8, 4'h1);
    m_ready = 1'b1;
    tick();
    lat = 0;
    while (!obs_valid && lat < 10) begin tick(); lat++; end
    n_cmp++;
    if (lat != 2) begin n_fail++; $display("FAIL stream_latency: got %0d want 2", lat); end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      want = 4'h1 + k[3:0];
      n_cmp += 2;
      if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, obs_valid); end
      if (obs_data !== want) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", k, obs_data, want); end
      exp_idx++;
    end
    tick();
    n_cmp++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle: got %b want 0", obs_valid); end
  endtask

  task automatic test_backpressure();
    int pulses;
    int guard;
    m_ready = 1'b0;
    load(8, 4'h1);
    pulses = 0;
    repeat (10) begin
      tick();
      if (obs_acc) pulses++;
      if (obs_valid) begin
        n_cmp++;
        if (obs_data !== 4'h1) begin n_fail++; $display("FAIL bp_hold: got %h want 1", obs_data); end
      end
    end
    n_cmp += 3;
    if (pulses != 2) begin n_fail++; $display("FAIL bp_rinc_pulses: got %0d want 2", pulses); end
    if (acc_cnt - pop_cnt != 2) begin n_fail++; $display("FAIL bp_buffered: got %0d want 2", acc_cnt - pop_cnt); end
    if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", obs_valid); end
    m_ready = 1'b1;
    guard = 0;
    while (exp_idx < wptr && guard < 40) begin
      tick();
      if (obs_pop) begin
        n_cmp++;
        if (obs_data !== mem[exp_idx[10:0]]) begin
          n_fail++; $display("FAIL bp_drain_data: got %h want %h", obs_data, mem[exp_idx[10:0]]);
        end
        exp_idx++;
      end
      guard++;
    end
    n_cmp++;
    if (exp_idx != wptr) begin n_fail++; $display("FAIL bp_drain_count: got %0d want %0d", exp_idx, wptr); end
    tick();
    n_cmp++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", obs_valid); end
  endtask

  task automatic test_random();
    int guard;
    load(1000, 4'h0);
    guard = 0;
    while (exp_idx < wptr && guard < 8000) begin
      m_ready    = 1'($urandom_range(0, 1));
      hold_empty = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp += 2;
      if (obs_rinc && obs_empty) begin n_fail++; $display("FAIL rnd_rinc_empty: got 1 want 0"); end
      if (acc_cnt - pop_cnt > 2) begin n_fail++; $display("FAIL rnd_level: got %0d want <=2", acc_cnt - pop_cnt); end
      if (obs_pop) begin
        n_cmp++;
        if (obs_data !== mem[exp_idx[10:0]]) begin
          n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", exp_idx, obs_data, mem[exp_idx[10:0]]);
        end
        exp_idx++;
      end
      guard++;
    end
    hold_empty = 1'b0;
    m_ready    = 1'b1;
    n_cmp++;
    if (exp_idx != wptr) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", exp_idx, wptr); end
    tick();
  endtask

  task automatic test_reset_mid();
    int start;
    int guard;
    m_ready = 1'b1;
    load(8, 4'h9);
    start = pop_cnt;
    guard = 0;
    while (pop_cnt - start < 3 && guard < 20) begin
      tick();
      if (obs_pop) begin
        n_cmp++;
        if (obs_data !== mem[exp_idx[10:0]]) begin
          n_fail++; $display("FAIL mid_pre_data: got %h want %h", obs_data, mem[exp_idx[10:0]]);
        end
        exp_idx++;
      end
      guard++;
    end
    resetn = 1'b0;
    #1;
    n_cmp += 4;
    if (m_valid !== 1'b0)   begin n_fail++; $display("FAIL mid_valid: got %b want 0", m_valid); end
    if (m_data !== 4'h0)    begin n_fail++; $display("FAIL mid_data: got %h want 0", m_data); end
    if (fifo_rinc !== 1'b0) begin n_fail++; $display("FAIL mid_rinc: got %b want 0", fifo_rinc); end
    if (rptr - exp_idx != 2) begin n_fail++; $display("FAIL mid_outstanding: got %0d want 2", rptr - exp_idx); end
    @(negedge clk);
    exp_idx = rptr;
    acc_cnt = 0;
    pop_cnt = 0;
    resetn  = 1'b1;
    guard = 0;
    while (exp_idx < wptr && guard < 40) begin
      tick();
      if (obs_pop) begin
        n_cmp++;
        if (obs_data !== mem[exp_idx[10:0]]) begin
          n_fail++; $display("FAIL mid_resume_data: got %h want %h", obs_data, mem[exp_idx[10:0]]);
        end
        exp_idx++;
      end
      guard++;
    end
    n_cmp++;
    if (exp_idx != wptr) begin n_fail++; $display("FAIL mid_resume_count: got %0d want %0d", exp_idx, wptr); end
    tick();
    n_cmp++;
    if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b want 0", obs_valid); end
  endtask

  task automatic test_rdlat0();
    int lat;
    int pulses;
    logic [3:0] want;
    for (int k = 0; k < 12; k++) mem0[k] = 4'h1 + k[3:0];
    m_ready0 = 1'b1;
    wptr0 = 8;
    #1;
    lat = 0;
    while (!m_valid0 && lat < 10) begin @(negedge clk); #1; lat++; end
    n_cmp++;
    if (lat != 1) begin n_fail++; $display("FAIL lat0_latency: got %0d want 1", lat); end
    for (int k = 0; k < 8; k++) begin
      want = 4'h1 + k[3:0];
      n_cmp += 2;
      if (m_valid0 !== 1'b1) begin n_fail++; $display("FAIL lat0_valid[%0d]: got %b want 1", k, m_valid0); end
      if (m_data0 !== want) begin n_fail++; $display("FAIL lat0_data[%0d]: got %h want %h", k, m_data0, want); end
      @(negedge clk); #1;
    end
    n_cmp++;
    if (m_valid0 !== 1'b0) begin n_fail++; $display("FAIL lat0_idle: got %b want 0", m_valid0); end
    @(negedge clk);
    m_ready0 = 1'b0;
    wptr0 = 12;
    pulses = 0;
    repeat (6) begin
      #1;
      if (fifo_rinc0 && !fifo_empty0) pulses++;
      @(negedge clk);
    end
    n_cmp += 2;
    if (pulses != 2) begin n_fail++; $display("FAIL lat0_bp_pulses: got %0d want 2", pulses); end
    if (m_data0 !== 4'h9) begin n_fail++; $display("FAIL lat0_bp_hold: got %h want 9", m_data0); end
    m_ready0 = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      want = 4'h9 + k[3:0];
      n_cmp++;
      if (m_valid0 !== 1'b1 || m_data0 !== want) begin
        n_fail++; $display("FAIL lat0_bp_data[%0d]: got %b/%h want 1/%h", k, m_valid0, m_data0, want);
      end
      @(negedge clk); #1;
    end
    n_cmp++;
    if (m_valid0 !== 1'b0) begin n_fail++; $display("FAIL lat0_bp_no_dup: got %b want 0", m_valid0); end
    @(negedge clk);
  endtask

`ifdef FIFO_RD_STREAM_CNT_EN
  task automatic test_beat_cnt();
    int guard;
    n_cmp += 2;
    if (beat_cnt !== pop_cnt[15:0]) begin n_fail++; $display("FAIL cnt_track: got %h want %h", beat_cnt, pop_cnt[15:0]); end
    if (beat_cnt0 !== 16'd12) begin n_fail++; $display("FAIL cnt0_track: got %h want 000c", beat_cnt0); end
    resetn = 1'b0;
    tick();
    n_cmp++;
    if (beat_cnt !== 16'h0000) begin n_fail++; $display("FAIL cnt_reset: got %h want 0000", beat_cnt); end
    exp_idx = rptr;
    pop_cnt = 0;
    acc_cnt = 0;
    m_ready = 1'b1;
    resetn  = 1'b1;
    wptr    = wptr + 65537;
    guard = 0;
    while (pop_cnt < 65537 && guard < 70000) begin
      if (pop_cnt == 65536) m_ready = 1'b1;
      tick();
      guard++;
      if (pop_cnt == 65537) m_ready = 1'b0;
    end
    n_cmp += 2;
    if (pop_cnt != 65537) begin n_fail++; $display("FAIL cnt_pops: got %0d want 65537", pop_cnt); end
    if (beat_cnt !== 16'h0001) begin n_fail++; $display("FAIL cnt_wrap: got %h want 0001", beat_cnt); end
  endtask
`endif

  initial begin
    resetn     = 1'b0;
    m_ready    = 1'b1;
    m_ready0   = 1'b1;
    hold_empty = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_rdlat0();
`ifdef FIFO_RD_STREAM_CNT_EN
    test_beat_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
